// File: rtl/tone_pkg.sv
// Shared constants and types for the tone frame generator.
// Cosine table is Q1.14 over one 8-point period.
package tone_pkg;

  localparam int LUT_FRAC  = 14;
  localparam int FRAME_LEN = 8;

  localparam logic signed [15:0] COS_Q14 [0:7] = '{
    16'sd16384,
    16'sd11585,
    16'sd0,
    -16'sd11585,
    -16'sd16384,
    -16'sd11585,
    16'sd0,
    16'sd11585
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tone_state_t;

endpackage

// File: rtl/tone_frame_generator_if.sv
// Sample stream handshake between the generator and the DFT path.
// The generator is the master; the consumer drives sample_ready.
interface tone_frame_generator_if #(
  parameter int SAMPLE_W = 18
);

  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_valid;
  logic                       sample_ready;
  logic                       sample_last;

  modport master (
    output sample,
    output sample_valid,
    output sample_last,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  sample_last,
    output sample_ready
  );

endinterface

// File: rtl/tone_cos_lut.sv
// Combinational Q1.14 cosine lookup for an 8-point phase.
// Phase 0..7 maps to cos(2*pi*phase/8).
module tone_cos_lut
  import tone_pkg::*;
(
  input  logic [2:0]         phase,
  output logic signed [15:0] cos_val
);

  assign cos_val = COS_Q14[phase];

endmodule

// File: rtl/tone_frame_generator.sv
// Bursts of 8-sample scaled-cosine frames plus DC offset,
// one sample per valid/ready handshake.
module tone_frame_generator
  import tone_pkg::*;
#(
  parameter int SAMPLE_W    = 18,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2:0]             bin_idx,
  input  logic signed [15:0]     amplitude,
  input  logic signed [15:0]     dc_offset,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  tone_frame_generator_if.master sif,
  output logic                   busy,
  output logic                   done
);

  tone_state_t state, state_nxt;

  logic [2:0]             bin_q;
  logic [2:0]             phase;
  logic [2:0]             n;
  logic [2:0]             phase_nxt;
  logic [2:0]             phase_sel;
  logic signed [15:0]     amp_q;
  logic signed [15:0]     dc_q;
  logic signed [15:0]     amp_sel;
  logic signed [15:0]     dc_sel;
  logic signed [15:0]     cos_val;
  logic [FRAME_CNT_W-1:0] nf_q;
  logic [FRAME_CNT_W-1:0] frame;
  logic signed [31:0]     prod;
  logic signed [31:0]     scaled;
  logic signed [SAMPLE_W-1:0] calc;
  logic                   hs;
  logic                   last_frame;
  logic                   final_hs;
  logic                   go;

  assign hs = sif.sample_valid && sif.sample_ready;
  assign go = (state == IDLE) && start && !abort;

  assign last_frame = (nf_q != '0) &&
                      (frame + FRAME_CNT_W'(1) == nf_q);
  assign final_hs = hs && (n == 3'd7) && last_frame;

  // Phase returns to 0 at each frame boundary.
  assign phase_nxt = (n == 3'd7) ? 3'd0 : phase + bin_q;

  // In IDLE the first sample is built straight from the inputs.
  assign phase_sel = (state == IDLE) ? 3'd0 : phase_nxt;
  assign amp_sel   = (state == IDLE) ? amplitude : amp_q;
  assign dc_sel    = (state == IDLE) ? dc_offset : dc_q;

  tone_cos_lut u_lut (
    .phase   (phase_sel),
    .cos_val (cos_val)
  );

  assign prod   = 32'(amp_sel) * 32'(cos_val);
  assign scaled = prod >>> LUT_FRAC;
  assign calc   = SAMPLE_W'(scaled) + SAMPLE_W'(dc_sel);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (final_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sif.sample       <= '0;
      sif.sample_valid <= 1'b0;
      sif.sample_last  <= 1'b0;
      bin_q            <= '0;
      amp_q            <= '0;
      dc_q             <= '0;
      nf_q             <= '0;
      phase            <= '0;
      n                <= '0;
      frame            <= '0;
    end else if (abort) begin
      sif.sample_valid <= 1'b0;
      sif.sample_last  <= 1'b0;
    end else if (go) begin
      bin_q            <= bin_idx;
      amp_q            <= amplitude;
      dc_q             <= dc_offset;
      nf_q             <= num_frames;
      phase            <= '0;
      n                <= '0;
      frame            <= '0;
      sif.sample       <= calc;
      sif.sample_valid <= 1'b1;
      sif.sample_last  <= 1'b0;
    end else if (state == RUN && hs) begin
      if (n == 3'd7) frame <= frame + FRAME_CNT_W'(1);
      if (final_hs) begin
        sif.sample_valid <= 1'b0;
        sif.sample_last  <= 1'b0;
      end else begin
        phase            <= phase_nxt;
        n                <= n + 3'd1;
        sif.sample       <= calc;
        sif.sample_valid <= 1'b1;
        sif.sample_last  <= (n == 3'd6);
      end
    end
  end

endmodule

// File: tb/tb_tone_frame_generator.sv
// Randomised bench for tone_frame_generator against an
// arithmetic cosine model of each burst.
module tb_tone_frame_generator;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [2:0]        bin_idx;
  logic signed [15:0] amplitude;
  logic signed [15:0] dc_offset;
  logic [7:0]        num_frames;
  logic              busy;
  logic              done;

  int n_pass = 0;
  int n_chk  = 0;

  int cos_tab [0:7] = '{16384, 11585, 0, -11585,
                        -16384, -11585, 0, 11585};

  tone_frame_generator_if #(.SAMPLE_W(18)) sif ();

  tone_frame_generator #(
    .SAMPLE_W    (18),
    .FRAME_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bin_idx    (bin_idx),
    .amplitude  (amplitude),
    .dc_offset  (dc_offset),
    .num_frames (num_frames),
    .sif        (sif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // floor(amp*cos(2*pi*k*n/8)*2^14 / 2^14) + dc
  function automatic longint ref_sample(input int k, input int amp,
                                        input int dc, input int i);
    int ph;
    longint p;
    longint q;
    ph = (k * (i % 8)) % 8;
    p  = longint'(amp) * longint'(cos_tab[ph]);
    q  = p / 16384;
    if (p < 0 && (p % 16384) != 0) q = q - 1;
    return q + dc;
  endfunction

  // mode 0: run to completion, 1: abort after stop_at, 2: rst after stop_at
  task automatic run_burst(input int k, input int amp, input int dc,
                           input int nf, input int stall,
                           input int stop_at, input int mode);
    int idx;
    int cyc;
    int limit;
    int stall_left;
    bit did_stall;
    bit stalled_prev;
    longint hold_s;
    longint hold_l;
    bit rdy;
    idx = 0;
    cyc = 0;
    stall_left = 0;
    did_stall = 0;
    stalled_prev = 0;
    hold_s = 0;
    hold_l = 0;
    limit = (mode == 0) ? nf * 8 : stop_at;

    @(negedge clk);
    start      = 1'b1;
    bin_idx    = 3'(k);
    amplitude  = 16'(amp);
    dc_offset  = 16'(dc);
    num_frames = 8'(nf);
    @(negedge clk);
    start = 1'b0;
    chk("busy_t1", busy, 1);
    chk("valid_t1", sif.sample_valid, 1);

    while (idx < limit && cyc < 4000) begin
      chk("done_low_run", done, 0);
      if (stalled_prev) begin
        chk("stall_hold_sample", sif.sample, hold_s);
        chk("stall_hold_last", sif.sample_last, hold_l);
      end
      rdy = 1'b1;
      if (stall == 1) rdy = ($urandom_range(0, 2) != 0);
      if (stall == 2) begin
        if (idx == 3 && !did_stall) begin
          did_stall = 1;
          stall_left = 3;
        end
        rdy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      sif.sample_ready = rdy;
      bin_idx    = 3'($urandom);
      amplitude  = 16'($urandom);
      dc_offset  = 16'($urandom);
      num_frames = 8'($urandom);
      start      = 1'($urandom_range(0, 1));
      if (sif.sample_valid && rdy) begin
        chk("sample", sif.sample, ref_sample(k, amp, dc, idx));
        chk("last", sif.sample_last, longint'((idx % 8) == 7));
        idx++;
        stalled_prev = 0;
      end else begin
        stalled_prev = sif.sample_valid;
        hold_s = sif.sample;
        hold_l = sif.sample_last;
      end
      cyc++;
      @(negedge clk);
    end

    start = 1'b0;
    sif.sample_ready = 1'b1;
    if (idx < limit) chk("timeout", idx, limit);

    if (mode == 0) begin
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("valid_done", sif.sample_valid, 0);
      if (stall == 0) chk("burst_cycles", cyc, 8 * nf);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("busy_idle", busy, 0);
    end else if (mode == 1) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", sif.sample_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
      end
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_sample", sif.sample, 0);
      chk("rst_valid", sif.sample_valid, 0);
      chk("rst_last", sif.sample_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bin_idx = '0;
    amplitude = '0;
    dc_offset = '0;
    num_frames = '0;
    sif.sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_sample", sif.sample, 0);
    chk("reset_valid", sif.sample_valid, 0);
    chk("reset_last", sif.sample_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_burst(3, 16384, 0, 1, 0, 0, 0);
    run_burst(2, 16384, 0, 1, 0, 0, 0);
    run_burst(6, 16384, 0, 1, 0, 0, 0);
    run_burst(0, -32768, 32767, 1, 0, 0, 0);
    run_burst(4, -32768, 32767, 1, 0, 0, 0);
    run_burst(1, 20000, -300, 2, 2, 0, 0);
    run_burst(1, 12345, 100, 0, 0, 45, 1);

    // abort beats start in the same IDLE cycle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_valid", sif.sample_valid, 0);

    run_burst(5, -7777, 2222, 0, 0, 5, 2);
    run_burst(5, -7777, 2222, 1, 0, 0, 0);

    for (int b = 0; b < 6; b++) begin
      run_burst(int'($urandom_range(0, 7)),
                int'(16'sh8000) + int'($urandom_range(0, 65535)),
                int'(16'sh8000) + int'($urandom_range(0, 65535)),
                int'($urandom_range(1, 3)), 1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tone_frame_generator.md
# tone_frame_generator

Synthesises 8-sample test frames of a scaled cosine at a chosen DFT bin (0–7) plus DC offset, streamed one sample per handshake. It drives the sample input of the 8-point DFT path so the peak-frequency detector can be exercised on-chip with known tones. It is the stimulus end of the chain whose far end reports `peak_frequency`.

## Interface
- `SAMPLE_W`, default 18: output sample width, signed. Minimum 18; no overflow for any input.
- `FRAME_CNT_W`, default 8: width of `num_frames`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a burst. Sampled only in IDLE.
- `abort` in 1: terminate the burst immediately.
- `bin_idx` in 3: tone bin k, 0..7.
- `amplitude` in 16 signed: Q15 peak amplitude.
- `dc_offset` in 16 signed: added to every sample.
- `num_frames` in `FRAME_CNT_W`: frames per burst. 0 means continuous until `abort`.
- `sample` out `SAMPLE_W` signed: sample data.
- `sample_valid` out 1: sample is valid.
- `sample_ready` in 1: downstream accepts the sample.
- `sample_last` out 1: marks sample n=7 of each frame. Qualified by `sample_valid`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on normal burst completion.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. In the same cycle, latch `bin_idx`, `amplitude`, `dc_offset` and `num_frames`, and clear phase, sample index n and frame counter.
  - RUN → DONE after the handshake (`sample_valid && sample_ready`) of sample n=7 in the final frame.
  - DONE → IDLE unconditionally. `done`=1 in DONE only.
  - `start` is ignored in RUN and DONE.
- Phase: 3-bit accumulator. Starts at 0 and adds k on each handshake, wrapping mod 8. Phase is 0 again at every frame start.
- Bins 5..7 produce samples identical to bins 3..1, since cos(2π(8−k)n/8) = cos(2πkn/8).
- Cosine LUT, Q1.14, indexed by phase 0..7: 16384, 11585, 0, −11585, −16384, −11585, 0, 11585.
- Arithmetic:
  - 32-bit signed product `amplitude`×cos.
  - Arithmetic shift right by 14, truncating toward −∞. Result range is [−32768, 32768].
  - Sign-extend, then add sign-extended `dc_offset`. Result range [−65536, 65535] fits 18 bits.
  - No saturation or rounding.
- Output register: loads the next sample when `!sample_valid || sample_ready`. While `sample_valid && !sample_ready`, `sample` and `sample_last` hold stable.
- Frame counter: increments on the n=7 handshake. Completion is when the count reaches `num_frames`. With `num_frames`=0 the generator never completes.
- `abort` in any state:
  - Next cycle: IDLE, `sample_valid`=0, `busy`=0.
  - No `done` pulse. A pending sample is discarded.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the burst does not start.

## Timing
- Reset values: `sample`=0, `sample_valid`=0, `sample_last`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- `rst` mid-burst behaves like `abort` and also clears the output data.
- Latency:
  - `start` accepted at cycle T gives `busy`=1 and `sample_valid`=1 with sample n=0 at T+1.
  - With `sample_ready` held high, one sample per cycle. An N-frame burst ends its last handshake at T+8N.
  - `done` is high at T+8N+1, and IDLE resumes at T+8N+2.
- A new `start` is accepted in IDLE only, so the earliest restart is T+8N+2.
- `sample_valid` never drops mid-burst except on `abort`/`rst`. There are no bubbles.

## Structure
- Package `tone_pkg` holds:
  - Localparam array `COS_Q14[0:7]`.
  - Enum `tone_state_t` {IDLE, RUN, DONE}.
  - Localparams `LUT_FRAC=14` and `FRAME_LEN=8`.
- Sub-module `tone_cos_lut`: 3-bit phase in, 16-bit signed Q1.14 out, purely combinational.
- Top-level module: FSM, counters, multiply/add and the output register.

## Test plan
- Bin 3, amplitude 16384, dc 0, 1 frame, ready=1 → samples 16384, −11585, 0, 11585, −16384, 11585, 0, −11585. `sample_last` on the 8th sample; `done` one cycle later.
- Bin 2 and bin 6, amplitude 16384 → both give 16384, 0, −16384, 0, 16384, 0, −16384, 0.
- Bin 0, amplitude −32768, dc 32767 → every sample −1. Bin 4, same inputs → alternating −1, 65535 (maximum positive case).
- Bin 1, 2 frames, `sample_ready` low for 3 cycles while sample n=3 is presented:
  - −11585×… sample holds stable during the stall.
  - 16 handshakes total; `sample_last` twice; `done` after the 16th.
- `num_frames`=0, bin 1:
  - Runs more than 40 samples with no `done`.
  - `abort` → `sample_valid`=0 next cycle, `done` never pulses, IDLE.
- `start` pulsed during RUN is ignored and the burst is unchanged.
- `rst` asserted at sample n=5 → all outputs reach reset values next cycle.
- A fresh `start` afterwards begins again at n=0, phase 0.
